iq_sum_tree_acc: RTL and testbench
==================================

// Module: iq_sum_tree_acc
// PURPOSE
//  Parametrised, fully pipelined complex (I/Q) summation of NUM_CH channels. Provides a per-channel
//  enable mask, optional coherent accumulation over acc_len beats, arithmetic scaling and output
//  saturation. Sits after the per-channel front-end (16-bit I/Q) and feeds beamsum/detection logic.
//  Accepts one input beat per clock.
// PARAMETERS
//  NUM_CH   35  channel count, 2..64
//  IN_W     16  input sample width, signed two's complement
//  OUT_W    22  output width, signed
//  ACC_W    4   width of acc_len; max frame = 2**ACC_W-1 beats
//  SHIFT    0   arithmetic right shift applied before saturation, 0..FULL_W-1
// PORTS
//  clk             in   1              rising-edge clock
//  rst             in   1              synchronous, active-high reset
//  data_in_i       in   NUM_CH*IN_W    I samples; channel k at [k*IN_W +: IN_W]
//  data_in_q       in   NUM_CH*IN_W    Q samples, same packing
//  ch_en           in   NUM_CH         per-channel enable; bit k=0 -> channel k contributes 0
//  data_in_valid   in   1              beat qualifier
//  acc_len         in   ACC_W          beats per output; 0 and 1 both mean no accumulation
//  sum_i           out  OUT_W          scaled, saturated I sum
//  sum_q           out  OUT_W          scaled, saturated Q sum
//  sat             out  1              1 if I or Q saturated on this output beat
//  data_out_valid  out  1              output qualifier, single-cycle pulse per result
// BEHAVIOUR
//  - Constants: LVL = clog2(NUM_CH); TREE_W = IN_W+LVL; FULL_W = TREE_W+ACC_W.
//  - Stage 0: register inputs. Sign-extend to TREE_W. Zero disabled channels (ch_en is sampled with the same beat).
//  - Stages 1..LVL: binary adder tree, one register level per stage. Odd leftover node passes through
//    a register to keep alignment. Valid is delayed alongside the data. No overflow is possible in the tree.
//  - Stage LVL+1: accumulate, scale, saturate and register the outputs.
//  - Latency: input beat at cycle t -> data_out_valid at t+LVL+2 (8 for NUM_CH=35) when acc_len<=1.
//    Throughput is 1 beat/clk. Gaps in data_in_valid are allowed; invalid beats never change state.
//  - Accumulation: a beat counter cnt, 0..acc_len-1.
//    - acc_len is latched on the tree-valid beat where cnt==0; changes mid-frame are ignored.
//    - On each tree-valid beat: acc <= (cnt==0 ? tree : acc+tree); cnt increments.
//    - On the beat where cnt==len-1: emit a result and set cnt to 0.
//    - Accumulator width FULL_W; it never wraps.
//  - Output: y = acc_next >>> SHIFT (arithmetic, truncating toward -inf).
//    - y > 2**(OUT_W-1)-1 clamps to max; y < -2**(OUT_W-1) clamps to min.
//    - sat is the OR over the I and Q rails.
//  - Output hold: sum_i/sum_q/sat hold their last values between pulses. data_out_valid is low otherwise.
//  - Reset (any time, including mid-frame):
//    - all pipeline valids, cnt, acc, sum_i, sum_q, sat and data_out_valid go to 0 on the next edge;
//    - in-flight beats and any partial frame are discarded, so no output follows from them;
//    - the first valid beat after reset deasserts starts a new frame.
//  - Data registers (not valids) may be left without reset in the tree stages; outputs must reset.
// STRUCTURE
//  - Package iq_sum_pkg: function clog2, and localparam helpers for LVL, TREE_W and FULL_W.
//  - Sub-module iq_add_tree: a single-rail pipelined tree (params NUM_CH, IN_W; ports clk, rst,
//    in bus, mask, vld_in, sum, vld_out). Instantiated once for I and once for Q; the I valid is used.
//  - Top level holds the accumulator/counter FSM and the scale/saturate logic, both shared by the two rails.
// TESTING (NUM_CH=35, IN_W=16, OUT_W=22, ACC_W=4, SHIFT=0 unless stated)
//  1. All channels I=16'h7FFF, Q=16'h8000, ch_en all 1, acc_len=1, one valid beat
//     -> 8 cycles later: sum_i=1146845, sum_q=-1146880 (22'h2E8000), sat=0, a single-cycle valid.
//  2. ch_en=only bits 0 and 34, I0=100, I34=-30, every other channel I=16'h7FFF
//     -> sum_i=70. Then 20 back-to-back beats with I0=k -> 20 consecutive valids, sum_i=k-30, in order.
//  3. acc_len=4, all I=16'h7FFF, four valid beats with random 0..3-cycle gaps
//     -> exactly one valid, sum_i=22'h1FFFFF, sat=1.
//  4. Same as 3 with SHIFT=2 -> sum_i=1146845 (4587380>>>2), sat=0.
//  5. acc_len=4, rst pulsed for 1 cycle after beat 2, then 4 beats of I=1 on all channels
//     -> no output from the partial frame; the next valid shows sum_i=140.
//  6. Change acc_len 4->2 mid-frame -> the current frame still spans 4 beats; the following frames span 2.

Source files
------------

// File: rtl/iq_sum_pkg.sv
// Shared defaults and width helpers for the I/Q summation tree.
// Widths are derived from the channel count so both rails and the top agree.
package iq_sum_pkg;

  localparam int DEF_NUM_CH = 35;
  localparam int DEF_IN_W   = 16;
  localparam int DEF_OUT_W  = 22;
  localparam int DEF_ACC_W  = 4;
  localparam int DEF_SHIFT  = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int lvl_of(input int num_ch);
    return clog2(num_ch);
  endfunction

  function automatic int tree_w_of(input int num_ch, input int in_w);
    return in_w + clog2(num_ch);
  endfunction

  function automatic int full_w_of(input int num_ch, input int in_w, input int acc_w);
    return tree_w_of(num_ch, in_w) + acc_w;
  endfunction

endpackage

// File: rtl/iq_add_tree.sv
// Single-rail pipelined binary adder tree with per-channel mask.
// One input register stage, then one register per tree level; only the valids are reset.
module iq_add_tree
  import iq_sum_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IN_W   = DEF_IN_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH*IN_W-1:0]            in_bus,
  input  logic [NUM_CH-1:0]                 mask,
  input  logic                              vld_in,
  output logic [IN_W+clog2(NUM_CH)-1:0]     sum,
  output logic                              vld_out
);

  localparam int LVL    = lvl_of(NUM_CH);
  localparam int TREE_W = tree_w_of(NUM_CH, IN_W);

  logic signed [TREE_W-1:0] r_node [0:LVL][0:NUM_CH-1];
  logic        [LVL:0]      r_vld;

  function automatic int nodes_at(input int l);
    return (NUM_CH + (1 << l) - 1) >> l;
  endfunction

  // Clamp keeps unrolled dead branches inside the array bounds.
  function automatic int clamp_idx(input int i);
    return (i < NUM_CH) ? i : NUM_CH - 1;
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      r_node[0][k] <= mask[k] ? {{LVL{in_bus[k*IN_W+IN_W-1]}}, in_bus[k*IN_W +: IN_W]}
                              : '0;
    end
    for (int l = 1; l <= LVL; l++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (j < nodes_at(l)) begin
          if (2*j + 1 < nodes_at(l-1))
            r_node[l][j] <= r_node[l-1][clamp_idx(2*j)] + r_node[l-1][clamp_idx(2*j+1)];
          else
            r_node[l][j] <= r_node[l-1][clamp_idx(2*j)];
        end else begin
          r_node[l][j] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else     r_vld <= {r_vld[LVL-1:0], vld_in};
  end

  assign sum     = r_node[LVL][0];
  assign vld_out = r_vld[LVL];

endmodule

// File: rtl/iq_sum_tree_acc.sv
// Complex channel summation: two masked adder trees feeding a shared accumulator,
// arithmetic scaler and saturator. Outputs hold between result pulses.
module iq_sum_tree_acc
  import iq_sum_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*IN_W-1:0] data_in_i,
  input  logic [NUM_CH*IN_W-1:0] data_in_q,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic                   data_in_valid,
  input  logic [ACC_W-1:0]       acc_len,
  output logic [OUT_W-1:0]       sum_i,
  output logic [OUT_W-1:0]       sum_q,
  output logic                   sat,
  output logic                   data_out_valid
);

  localparam int TREE_W = tree_w_of(NUM_CH, IN_W);
  localparam int FULL_W = full_w_of(NUM_CH, IN_W, ACC_W);
  localparam int CMP_W  = ((FULL_W > OUT_W) ? FULL_W : OUT_W) + 1;
  localparam logic signed [CMP_W-1:0] C_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] C_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [TREE_W-1:0]        w_tree_i, w_tree_q;
  logic                     w_tvld;
  logic signed [FULL_W-1:0] w_ext_i, w_ext_q;
  logic signed [FULL_W-1:0] w_acc_nxt_i, w_acc_nxt_q;
  logic [ACC_W-1:0]         w_len_eff;
  logic                     w_first, w_last;
  logic [OUT_W:0]           w_res_i, w_res_q;

  logic [ACC_W-1:0]         r_cnt, r_len;
  logic signed [FULL_W-1:0] r_acc_i, r_acc_q;

  iq_add_tree #(.NUM_CH(NUM_CH), .IN_W(IN_W)) u_tree_i (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (data_in_i),
    .mask    (ch_en),
    .vld_in  (data_in_valid),
    .sum     (w_tree_i),
    .vld_out (w_tvld)
  );

  // Both rails share one valid pipeline; the Q copy is identical and left open.
  iq_add_tree #(.NUM_CH(NUM_CH), .IN_W(IN_W)) u_tree_q (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (data_in_q),
    .mask    (ch_en),
    .vld_in  (data_in_valid),
    .sum     (w_tree_q),
    .vld_out ()
  );

  // Returns {saturated, value}; shift truncates toward -inf before clamping.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [FULL_W-1:0] a);
    logic signed [CMP_W-1:0] y;
    y = a;
    y = y >>> SHIFT;
    if (y > C_MAX) return {1'b1, C_MAX[OUT_W-1:0]};
    if (y < C_MIN) return {1'b1, C_MIN[OUT_W-1:0]};
    return {1'b0, y[OUT_W-1:0]};
  endfunction

  always_comb begin
    w_first     = (r_cnt == '0);
    w_len_eff   = w_first ? acc_len : r_len;
    w_last      = (w_len_eff <= ACC_W'(1)) || (r_cnt == w_len_eff - ACC_W'(1));
    w_ext_i     = {{ACC_W{w_tree_i[TREE_W-1]}}, w_tree_i};
    w_ext_q     = {{ACC_W{w_tree_q[TREE_W-1]}}, w_tree_q};
    w_acc_nxt_i = w_first ? w_ext_i : r_acc_i + w_ext_i;
    w_acc_nxt_q = w_first ? w_ext_q : r_acc_q + w_ext_q;
    w_res_i     = scale_sat(w_acc_nxt_i);
    w_res_q     = scale_sat(w_acc_nxt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_len          <= '0;
      r_acc_i        <= '0;
      r_acc_q        <= '0;
      sum_i          <= '0;
      sum_q          <= '0;
      sat            <= 1'b0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      if (w_tvld) begin
        if (w_first) r_len <= acc_len;
        r_acc_i <= w_acc_nxt_i;
        r_acc_q <= w_acc_nxt_q;
        if (w_last) begin
          r_cnt          <= '0;
          sum_i          <= w_res_i[OUT_W-1:0];
          sum_q          <= w_res_q[OUT_W-1:0];
          sat            <= w_res_i[OUT_W] | w_res_q[OUT_W];
          data_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + ACC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_sum_tree_acc.sv
// Scoreboard bench for iq_sum_tree_acc; a SHIFT=2 copy runs alongside on the same stimulus.
module tb_iq_sum_tree_acc;

  localparam int NCH = 35;
  localparam int IW  = 16;
  localparam int OW  = 22;
  localparam int AW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*IW-1:0] data_in_i, data_in_q;
  logic [NCH-1:0]   ch_en;
  logic             data_in_valid;
  logic [AW-1:0]    acc_len;
  logic [OW-1:0]    sum_i, sum_q, sum_i2, sum_q2;
  logic             sat, sat2, data_out_valid, data_out_valid2;

  always #5 clk = ~clk;

  iq_sum_tree_acc #(.NUM_CH(NCH), .IN_W(IW), .OUT_W(OW), .ACC_W(AW), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .data_in_i(data_in_i), .data_in_q(data_in_q), .ch_en(ch_en),
    .data_in_valid(data_in_valid), .acc_len(acc_len), .sum_i(sum_i), .sum_q(sum_q),
    .sat(sat), .data_out_valid(data_out_valid)
  );

  iq_sum_tree_acc #(.NUM_CH(NCH), .IN_W(IW), .OUT_W(OW), .ACC_W(AW), .SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .data_in_i(data_in_i), .data_in_q(data_in_q), .ch_en(ch_en),
    .data_in_valid(data_in_valid), .acc_len(acc_len), .sum_i(sum_i2), .sum_q(sum_q2),
    .sat(sat2), .data_out_valid(data_out_valid2)
  );

  typedef struct {
    logic [OW-1:0] i0, q0, i2, q2;
    logic          s0, s2;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_out = 0;
  logic [IW-1:0] ch_i [NCH];
  logic [IW-1:0] ch_q [NCH];

  function automatic logic [OW:0] rail(input longint full, input int sh);
    longint y;
    y = full >>> sh;
    if (y > longint'(2097151))  return {1'b1, 22'h1FFFFF};
    if (y < -longint'(2097152)) return {1'b1, 22'h200000};
    return {1'b0, y[OW-1:0]};
  endfunction

  function automatic void push_exp(input longint fi, input longint fq);
    exp_t e;
    logic [OW:0] ri0, rq0, ri2, rq2;
    ri0 = rail(fi, 0);
    rq0 = rail(fq, 0);
    ri2 = rail(fi, 2);
    rq2 = rail(fq, 2);
    e.i0 = ri0[OW-1:0];
    e.q0 = rq0[OW-1:0];
    e.s0 = ri0[OW] | rq0[OW];
    e.i2 = ri2[OW-1:0];
    e.q2 = rq2[OW-1:0];
    e.s2 = ri2[OW] | rq2[OW];
    sb.push_back(e);
  endfunction

  task automatic set_all(input logic [IW-1:0] vi, input logic [IW-1:0] vq);
    for (int k = 0; k < NCH; k++) begin
      ch_i[k] = vi;
      ch_q[k] = vq;
    end
  endtask

  task automatic apply_beat();
    for (int k = 0; k < NCH; k++) begin
      data_in_i[k*IW +: IW] = ch_i[k];
      data_in_q[k*IW +: IW] = ch_q[k];
    end
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic idle_garbage(input int n);
    repeat (n) begin
      for (int k = 0; k < NCH; k++) begin
        data_in_i[k*IW +: IW] = IW'($urandom);
        data_in_q[k*IW +: IW] = IW'($urandom);
      end
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (data_out_valid === 1'b1 || data_out_valid2 === 1'b1) begin
      n_vec++;
      if (data_out_valid !== data_out_valid2) begin
        n_err++;
        $display("FAIL valid_align shift0=%b shift2=%b want equal", data_out_valid, data_out_valid2);
      end
    end
    if (data_out_valid === 1'b1) begin
      n_out++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got i=%h q=%h sat=%b want no output", sum_i, sum_q, sat);
      end else begin
        e = sb.pop_front();
        if ({sum_i, sum_q, sat} !== {e.i0, e.q0, e.s0}) begin
          n_err++;
          $display("FAIL result_shift0 got i=%h q=%h sat=%b want i=%h q=%h sat=%b",
                   sum_i, sum_q, sat, e.i0, e.q0, e.s0);
        end
        n_vec++;
        if ({sum_i2, sum_q2, sat2} !== {e.i2, e.q2, e.s2}) begin
          n_err++;
          $display("FAIL result_shift2 got i=%h q=%h sat=%b want i=%h q=%h sat=%b",
                   sum_i2, sum_q2, sat2, e.i2, e.q2, e.s2);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({sum_i, sum_q, sat, data_out_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_shift0 got i=%h q=%h sat=%b v=%b want all 0", sum_i, sum_q, sat, data_out_valid);
    end
    n_vec++;
    if ({sum_i2, sum_q2, sat2, data_out_valid2} !== '0) begin
      n_err++;
      $display("FAIL reset_shift2 got i=%h q=%h sat=%b v=%b want all 0", sum_i2, sum_q2, sat2, data_out_valid2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scale();
    int lat;
    int o;
    acc_len = 4'd1;
    ch_en   = '1;
    set_all(16'h7FFF, 16'h8000);
    o = n_out;
    push_exp(1146845, -1146880);
    apply_beat();
    lat = 1;
    while (data_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL latency got %0d cycles want 8", lat);
    end
    @(negedge clk);
    n_vec++;
    if (data_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width valid still %b one cycle later want 0", data_out_valid);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (sum_i !== 22'd1146845 || sum_q !== 22'h2E8000 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL hold got i=%h q=%h sat=%b want i=%h q=2e8000 sat=0", sum_i, sum_q, sat, 22'd1146845);
    end
    n_vec++;
    if (n_out - o !== 1) begin
      n_err++;
      $display("FAIL single_output got %0d outputs want 1", n_out - o);
    end
  endtask

  task automatic test_mask_back_to_back();
    ch_en     = '0;
    ch_en[0]  = 1'b1;
    ch_en[34] = 1'b1;
    set_all(16'h7FFF, 16'h8000);
    ch_i[0]  = 16'd100;
    ch_i[34] = -16'sd30;
    ch_q[0]  = 16'd5;
    ch_q[34] = 16'd7;
    push_exp(70, 12);
    apply_beat();
    repeat (12) @(negedge clk);
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL mask_drain got %0d pending want 0", sb.size());
    end
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          ch_i[0] = IW'(k);
          push_exp(k - 30, 12);
          apply_beat();
        end
      end
      begin
        int t;
        int run;
        t   = 0;
        run = 0;
        while (data_out_valid !== 1'b1 && t < 60) begin
          @(negedge clk);
          t++;
        end
        while (data_out_valid === 1'b1 && run < 30) begin
          run++;
          @(negedge clk);
        end
        n_vec++;
        if (run !== 20) begin
          n_err++;
          $display("FAIL b2b_run got %0d consecutive valids want 20", run);
        end
      end
    join
    repeat (12) @(negedge clk);
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_accumulate_sat();
    int o;
    acc_len = 4'd4;
    ch_en   = '1;
    set_all(16'h7FFF, 16'h8000);
    o = n_out;
    push_exp(4 * 1146845, -4 * 1146880);
    for (int b = 0; b < 4; b++) begin
      apply_beat();
      idle_garbage($urandom_range(0, 3));
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (n_out - o !== 1) begin
      n_err++;
      $display("FAIL acc_outputs got %0d want 1", n_out - o);
    end
    n_vec++;
    if (sum_i !== 22'h1FFFFF || sum_q !== 22'h200000 || sat !== 1'b1) begin
      n_err++;
      $display("FAIL acc_sat got i=%h q=%h sat=%b want i=1fffff q=200000 sat=1", sum_i, sum_q, sat);
    end
    n_vec++;
    if (sum_i2 !== 22'd1146845 || sum_q2 !== 22'h2E8000 || sat2 !== 1'b0) begin
      n_err++;
      $display("FAIL acc_shift2 got i=%h q=%h sat=%b want i=%h q=2e8000 sat=0", sum_i2, sum_q2, sat2, 22'd1146845);
    end
  endtask

  task automatic test_reset_mid_frame();
    int o;
    acc_len = 4'd4;
    ch_en   = '1;
    set_all(16'h7FFF, 16'h7FFF);
    o = n_out;
    apply_beat();
    apply_beat();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({sum_i, sum_q, sat, data_out_valid} !== '0) begin
      n_err++;
      $display("FAIL midreset_clear got i=%h q=%h sat=%b v=%b want all 0", sum_i, sum_q, sat, data_out_valid);
    end
    set_all(16'd1, 16'd2);
    push_exp(140, 280);
    repeat (4) apply_beat();
    repeat (12) @(negedge clk);
    n_vec++;
    if (n_out - o !== 1 || sum_i !== 22'd140) begin
      n_err++;
      $display("FAIL midreset_frame got %0d outputs i=%h want 1 output i=%h", n_out - o, sum_i, 22'd140);
    end
  endtask

  task automatic test_len_change();
    int o;
    ch_en = '1;
    o = n_out;
    acc_len = 4'd4;
    push_exp(350, -350);
    push_exp(385, -385);
    push_exp(525, -525);
    set_all(IW'(1), IW'(-1));
    apply_beat();
    repeat (10) @(negedge clk);
    acc_len = 4'd2;
    for (int b = 2; b <= 8; b++) begin
      set_all(IW'(b), IW'(-b));
      apply_beat();
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (n_out - o !== 3) begin
      n_err++;
      $display("FAIL len_change_outputs got %0d want 3", n_out - o);
    end
    acc_len = 4'd0;
    set_all(16'd3, 16'd4);
    o = n_out;
    push_exp(105, 140);
    push_exp(105, 140);
    apply_beat();
    apply_beat();
    repeat (12) @(negedge clk);
    n_vec++;
    if (n_out - o !== 2 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL len_zero got %0d outputs %0d pending want 2 outputs 0 pending", n_out - o, sb.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    data_in_valid = 1'b0;
    data_in_i     = '0;
    data_in_q     = '0;
    ch_en         = '1;
    acc_len       = 4'd1;
    set_all('0, '0);
    test_reset();
    test_full_scale();
    test_mask_back_to_back();
    test_accumulate_sat();
    test_reset_mid_frame();
    test_len_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
